// File: rtl/lc3_mem_pkg.sv
// LC-3 memory unit shared definitions: data/address width,
// FSM state encoding and access-type encoding.
package lc3_mem_pkg;

    localparam int LC3_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/lc3_memory_unit_if.sv
// External memory bus of the LC-3 memory unit.
// master: address/data/strobes out, read data and ack in.
// slave : the memory side of the same bus.
interface lc3_memory_unit_if #(
    parameter int DW = 16
);
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_en, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_en, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lc3_mem_timer.sv
// Wait-cycle counter for a pending memory access.
// Ports: clk, reset, clear (restart at 0), enable (count one
// unacknowledged cycle), expired (last permitted cycle, no ack).
module lc3_mem_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);
endmodule

// File: rtl/lc3_memory_unit.sv
// LC-3 MAR/MDR memory interface with IDLE/BUSY/DONE handshake FSM.
// Ports: clk, reset, bus_in, ldMAR/ldMDR/selMDR/memWE/enaMDR controls,
// mdr_bus, R (ready pulse), mem_err (sticky timeout), mem (memory bus).
module lc3_memory_unit
    import lc3_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DW      = LC3_DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DW-1:0]             bus_in,
    input  logic                      ldMAR,
    input  logic                      ldMDR,
    input  logic                      selMDR,
    input  logic                      memWE,
    input  logic                      enaMDR,
    output logic [DW-1:0]             mdr_bus,
    output logic                      R,
    output logic                      mem_err,
    lc3_memory_unit_if.master         mem
);
    mem_state_e    state_q, state_d;
    mem_op_e       op_q, op_d;
    logic [DW-1:0] mar_q, mar_d;
    logic [DW-1:0] mdr_q, mdr_d;
    // Snapshot of MAR/MDR at access start, so a same-cycle
    // ldMAR/ldMDR does not disturb the access being launched.
    logic [DW-1:0] acc_addr_q, acc_addr_d;
    logic [DW-1:0] acc_wdata_q, acc_wdata_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          expired;
    logic          busy;

    assign busy = (state_q == ST_BUSY);

    lc3_mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !mem.mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ldMAR) begin
                    mar_d = bus_in;
                end
                if (ldMDR && !selMDR) begin
                    mdr_d = bus_in;
                end
                if (memWE) begin
                    op_d        = OP_WRITE;
                    state_d     = ST_BUSY;
                    acc_addr_d  = mar_q;
                    acc_wdata_d = mdr_q;
                end else if (ldMDR && selMDR) begin
                    op_d        = OP_READ;
                    state_d     = ST_BUSY;
                    acc_addr_d  = mar_q;
                    acc_wdata_d = mdr_q;
                end
            end
            ST_BUSY: begin
                if (mem.mem_ack) begin
                    if (op_q == OP_READ) begin
                        mdr_d = mem.mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        en_d = (state_d == ST_BUSY);
        we_d = (state_d == ST_BUSY) && (op_d == OP_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            mar_q       <= '0;
            mdr_q       <= '0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            en_q        <= en_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    // Outside BUSY the bus mirrors MAR/MDR; during BUSY it shows
    // the values captured when the access started.
    assign mem.mem_addr  = busy ? acc_addr_q  : mar_q;
    assign mem.mem_wdata = busy ? acc_wdata_q : mdr_q;
    assign mem.mem_en    = en_q;
    assign mem.mem_we    = we_q;

    assign mdr_bus = enaMDR ? mdr_q : '0;
    assign R       = (state_q == ST_DONE);
    assign mem_err = err_q;
endmodule

// File: tb/tb_lc3_memory_unit.sv
// Randomized self-checking bench for lc3_memory_unit with a
// behavioural MAR/MDR/memory model and a latency-programmable memory.
module tb_lc3_memory_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ldMAR, ldMDR, selMDR, memWE, enaMDR;
    logic [15:0] mdr_bus;
    logic        R, mem_err;

    lc3_memory_unit_if #(.DW(16)) mif ();

    lc3_memory_unit #(.TIMEOUT(TO), .DW(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus_in  (bus_in),
        .ldMAR   (ldMAR),
        .ldMDR   (ldMDR),
        .selMDR  (selMDR),
        .memWE   (memWE),
        .enaMDR  (enaMDR),
        .mdr_bus (mdr_bus),
        .R       (R),
        .mem_err (mem_err),
        .mem     (mif)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // memory responder
    logic [15:0] memory [0:255];
    int ack_delay = -1;
    int wcnt = 0;
    int en_cnt = 0, we_cnt = 0, r_cnt = 0;

    // reference model
    logic [15:0] model_mem [0:255];
    logic [15:0] m_mar, m_mdr;
    logic        m_err;

    always @(negedge clk) begin
        if (mif.mem_en) begin
            en_cnt++;
            if (mif.mem_we) we_cnt++;
            if (ack_delay >= 0 && wcnt == ack_delay) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = memory[mif.mem_addr[7:0]];
                if (mif.mem_we) memory[mif.mem_addr[7:0]] = mif.mem_wdata;
            end else begin
                mif.mem_ack   = 1'b0;
                mif.mem_rdata = 16'($urandom);
            end
            wcnt++;
        end else begin
            mif.mem_ack = 1'b0;
            wcnt = 0;
        end
        if (R) r_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ldMAR  = 1'b0;
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        memWE  = 1'b0;
    endtask

    task automatic run_until_r(input int max, output int cyc);
        cyc = -1;
        for (int i = 0; i < max; i++) begin
            if (R) begin
                cyc = i;
                return;
            end
            tick();
        end
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus_in = v; ldMAR = 1'b1;
        tick();
        idle_inputs();
        m_mar = v;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus_in = v; ldMDR = 1'b1; selMDR = 1'b0;
        tick();
        idle_inputs();
        m_mdr = v;
    endtask

    task automatic do_access(input bit wr, input int d, input bit ldm, input logic [15:0] nv);
        logic [15:0] a_exp, w_exp, m_exp;
        int cyc, en_exp;
        a_exp = m_mar; w_exp = m_mdr;
        ack_delay = d; en_cnt = 0; we_cnt = 0; r_cnt = 0;
        bus_in = nv; ldMAR = ldm;
        if (wr) memWE = 1'b1;
        else begin ldMDR = 1'b1; selMDR = 1'b1; end
        tick();
        idle_inputs();
        if (ldm) m_mar = nv;
        n_chk++;
        if (mif.mem_addr !== a_exp)
            $display("FAIL acc_addr: got %h want %h", mif.mem_addr, a_exp);
        else n_pass++;
        n_chk++;
        if (mif.mem_we !== wr)
            $display("FAIL acc_we: got %b want %b", mif.mem_we, wr);
        else n_pass++;
        if (wr) begin
            n_chk++;
            if (mif.mem_wdata !== w_exp)
                $display("FAIL acc_wdata: got %h want %h", mif.mem_wdata, w_exp);
            else n_pass++;
        end
        run_until_r(40, cyc);
        n_chk++;
        if (cyc < 0) $display("FAIL acc_ready: no R within 40 cycles");
        else n_pass++;
        tick();
        if (d < 0) m_err = 1'b1;
        else if (wr) model_mem[a_exp[7:0]] = w_exp;
        else m_mdr = model_mem[a_exp[7:0]];
        en_exp = (d < 0) ? TO : d + 1;
        n_chk++;
        if (en_cnt != en_exp)
            $display("FAIL acc_en_cycles: got %0d want %0d", en_cnt, en_exp);
        else n_pass++;
        n_chk++;
        if (r_cnt != 1) $display("FAIL acc_r_pulses: got %0d want 1", r_cnt);
        else n_pass++;
        n_chk++;
        if (mem_err !== m_err)
            $display("FAIL acc_err: got %b want %b", mem_err, m_err);
        else n_pass++;
        enaMDR = 1'b1; #1;
        m_exp = m_mdr;
        n_chk++;
        if (mdr_bus !== m_exp)
            $display("FAIL acc_mdr: got %h want %h", mdr_bus, m_exp);
        else n_pass++;
        enaMDR = 1'b0; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
        n_chk++;
        if ({mif.mem_en, mif.mem_we, R, mem_err} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {mif.mem_en, mif.mem_we, R, mem_err});
        else n_pass++;
        n_chk++;
        if ({mif.mem_addr, mif.mem_wdata} !== 32'h0)
            $display("FAIL reset_regs: got %h want 0", {mif.mem_addr, mif.mem_wdata});
        else n_pass++;
        enaMDR = 1'b1; #1;
        n_chk++;
        if (mdr_bus !== 16'h0) $display("FAIL reset_mdr_bus: got %h want 0", mdr_bus);
        else n_pass++;
        enaMDR = 1'b0; #1;
    endtask

    task automatic test_read();
        load_mar(16'h3000);
        memory[8'h00] = 16'h1234;
        model_mem[8'h00] = 16'h1234;
        ack_delay = 0;
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        idle_inputs();
        n_chk++;
        if ({mif.mem_en, mif.mem_we, R} !== 3'b100)
            $display("FAIL read_n1: en/we/R got %b want 100", {mif.mem_en, mif.mem_we, R});
        else n_pass++;
        n_chk++;
        if (mif.mem_addr !== 16'h3000)
            $display("FAIL read_addr: got %h want 3000", mif.mem_addr);
        else n_pass++;
        tick();
        n_chk++;
        if ({mif.mem_en, R} !== 2'b01)
            $display("FAIL read_n2: en/R got %b want 01", {mif.mem_en, R});
        else n_pass++;
        tick();
        n_chk++;
        if (R !== 1'b0) $display("FAIL read_r_single: got %b want 0", R);
        else n_pass++;
        m_mdr = 16'h1234;
        enaMDR = 1'b1; #1;
        n_chk++;
        if (mdr_bus !== 16'h1234) $display("FAIL read_mdr_bus: got %h want 1234", mdr_bus);
        else n_pass++;
        enaMDR = 1'b0; #1;
        n_chk++;
        if (mdr_bus !== 16'h0) $display("FAIL read_mdr_bus_off: got %h want 0", mdr_bus);
        else n_pass++;
    endtask

    task automatic test_write();
        load_mdr(16'hBEEF);
        load_mar(16'h0042);
        do_access(1'b1, 3, 1'b0, 16'h0);
        n_chk++;
        if (we_cnt != 4) $display("FAIL write_we_cycles: got %0d want 4", we_cnt);
        else n_pass++;
        n_chk++;
        if (memory[8'h42] !== 16'hBEEF)
            $display("FAIL write_mem: got %h want BEEF", memory[8'h42]);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        memory[8'h10] = 16'hDEAD;
        model_mem[8'h10] = 16'hDEAD;
        load_mdr(16'h5A5A);
        load_mar(16'h0010);
        ack_delay = 1; r_cnt = 0;
        memWE = 1'b1; ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        idle_inputs();
        n_chk++;
        if (mif.mem_we !== 1'b1) $display("FAIL simul_we: got %b want 1", mif.mem_we);
        else n_pass++;
        tick(); tick(); tick();
        model_mem[8'h10] = 16'h5A5A;
        enaMDR = 1'b1; #1;
        n_chk++;
        if (mdr_bus !== 16'h5A5A) $display("FAIL simul_mdr: got %h want 5A5A", mdr_bus);
        else n_pass++;
        enaMDR = 1'b0;
        n_chk++;
        if (memory[8'h10] !== 16'h5A5A)
            $display("FAIL simul_mem: got %h want 5A5A", memory[8'h10]);
        else n_pass++;
        n_chk++;
        if (r_cnt != 1) $display("FAIL simul_r: got %0d want 1", r_cnt);
        else n_pass++;
    endtask

    task automatic test_preload();
        load_mar(16'h0021);
        load_mdr(16'h7777);
        do_access(1'b1, 0, 1'b1, 16'h0055);
        n_chk++;
        if (memory[8'h21] !== 16'h7777)
            $display("FAIL preload_mem: got %h want 7777", memory[8'h21]);
        else n_pass++;
        n_chk++;
        if (mif.mem_addr !== 16'h0055)
            $display("FAIL preload_mar: got %h want 0055", mif.mem_addr);
        else n_pass++;
    endtask

    task automatic test_timeout();
        load_mar(16'h0033);
        do_access(1'b0, -1, 1'b0, 16'h0);
        do_access(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_busy_reset();
        load_mar(16'h0077);
        ack_delay = -1;
        ldMDR = 1'b1; selMDR = 1'b1;
        tick();
        idle_inputs();
        tick();
        bus_in = 16'hFFFF; ldMAR = 1'b1; ldMDR = 1'b1; memWE = 1'b1;
        tick();
        idle_inputs();
        n_chk++;
        if (mif.mem_addr !== 16'h0077)
            $display("FAIL busy_mar: got %h want 0077", mif.mem_addr);
        else n_pass++;
        n_chk++;
        if ({mif.mem_we, mif.mem_wdata} !== {1'b0, m_mdr})
            $display("FAIL busy_ignore: got %h want %h",
                     {mif.mem_we, mif.mem_wdata}, {1'b0, m_mdr});
        else n_pass++;
        tick();
        r_cnt = 0;
        ack_delay = wcnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_delay = -1;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
        n_chk++;
        if ({mif.mem_en, mif.mem_we, R, mem_err} !== 4'b0000)
            $display("FAIL rst_busy_flags: got %b want 0000",
                     {mif.mem_en, mif.mem_we, R, mem_err});
        else n_pass++;
        enaMDR = 1'b1; #1;
        n_chk++;
        if ({mif.mem_addr, mdr_bus} !== 32'h0)
            $display("FAIL rst_busy_regs: got %h want 0", {mif.mem_addr, mdr_bus});
        else n_pass++;
        enaMDR = 1'b0;
        tick(); tick(); tick();
        n_chk++;
        if (r_cnt != 0) $display("FAIL rst_busy_r: got %0d want 0", r_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int sel, d;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            d = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
            case (sel)
                0: load_mar(16'($urandom));
                1: load_mdr(16'($urandom));
                default: do_access(sel == 3, d, 1'($urandom_range(0, 1)),
                                   16'($urandom));
            endcase
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_in = '0; enaMDR = 1'b0;
        idle_inputs();
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            memory[i] = 16'($urandom);
            model_mem[i] = memory[i];
        end
        test_reset();
        test_read();
        test_write();
        test_simultaneous();
        test_preload();
        test_timeout();
        test_busy_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
